target_spawn_scheduler: RTL and testbench



---
 rtl/game_pkg.sv | 24 ++
 rtl/lfsr16.sv | 27 ++
 rtl/target_spawn_scheduler.sv | 161 ++++++++++++++++
 tb/tb_target_spawn_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the game datapath blocks.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StWaitVbl,
    StWrite,
    StGap,
    StDone
  } spawn_state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned DEF_SCREEN_WIDTH = 640;
  localparam int unsigned DEF_SPRITE_WIDTH = 8;

  // Folds an out-of-range raw coordinate back into 0..x_max without a divider.
  function automatic logic [15:0] fold_x(input logic [15:0] raw, input logic [15:0] x_max);
    if (raw <= x_max) return raw;
    return raw - x_max - 16'd1;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (shift right); a zero seed is replaced by 1.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  localparam logic [15:0] ResetVal = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = {1'b0, value_q[15:1]} ^ (value_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= ResetVal;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/target_spawn_scheduler.sv
// Walks enabled targets in index order, waits for vblank per target and issues
// one-cycle write strobes with a shared pseudo-random spawn position/velocity.
module target_spawn_scheduler
  import game_pkg::*;
#(
  parameter int unsigned N_TARGETS    = 3,
  parameter int unsigned X_WIDTH      = 10,
  parameter int unsigned Y_WIDTH      = 9,
  parameter int unsigned DXY_WIDTH    = 3,
  parameter int unsigned SCREEN_WIDTH = DEF_SCREEN_WIDTH,
  parameter int unsigned SPRITE_WIDTH = DEF_SPRITE_WIDTH,
  parameter int unsigned SPAWN_GAP    = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N_TARGETS-1:0] enable_mask,
  input  logic                 vblank,
  output logic                 busy,
  output logic                 done,
  output logic [N_TARGETS-1:0] spawned_mask,
  output logic [N_TARGETS-1:0] sprite_write_xy,
  output logic [N_TARGETS-1:0] sprite_write_dxy,
  output logic [X_WIDTH-1:0]   sprite_x,
  output logic [Y_WIDTH-1:0]   sprite_y,
  output logic [DXY_WIDTH-1:0] sprite_dx,
  output logic [DXY_WIDTH-1:0] sprite_dy
);

  localparam int unsigned IdxW    = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
  localparam logic [15:0] XMax    = 16'(SCREEN_WIDTH - SPRITE_WIDTH);
  localparam logic [7:0]  GapLast = 8'(SPAWN_GAP - 1);

  spawn_state_e         state_q, state_d;
  logic [N_TARGETS-1:0] pending_q, pending_d;
  logic [N_TARGETS-1:0] spawned_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [7:0]           gap_q, gap_d;
  logic                 latch_bus;

  logic                 busy_d, done_d;
  logic [N_TARGETS-1:0] strobe_q, strobe_d;
  logic [X_WIDTH-1:0]   x_d;
  logic [Y_WIDTH-1:0]   y_d;
  logic [DXY_WIDTH-1:0] dx_d, dy_d, dx_mag;
  logic [15:0]          r;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      spawned_mask <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      strobe_q     <= '0;
      sprite_x     <= '0;
      sprite_y     <= '0;
      sprite_dx    <= '0;
      sprite_dy    <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      spawned_mask <= spawned_d;
      busy         <= busy_d;
      done         <= done_d;
      strobe_q     <= strobe_d;
      sprite_x     <= x_d;
      sprite_y     <= y_d;
      sprite_dx    <= dx_d;
      sprite_dy    <= dy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    spawned_d = spawned_mask;
    latch_bus = 1'b0;
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            pending_d = enable_mask;
            spawned_d = '0;
            state_d   = StSelect;
          end
        end
        StSelect: begin
          if (pending_q == '0) begin
            state_d = StDone;
          end else begin
            // Downward scan leaves the lowest set bit as the final assignment.
            for (int i = int'(N_TARGETS) - 1; i >= 0; i--) begin
              if (pending_q[i]) idx_d = IdxW'(i);
            end
            state_d = StWaitVbl;
          end
        end
        StWaitVbl: begin
          if (vblank) begin
            // Bookkeeping moves with the strobe so an abort never splits them.
            latch_bus           = 1'b1;
            pending_d[idx_q]    = 1'b0;
            spawned_d[idx_q]    = 1'b1;
            state_d             = StWrite;
          end
        end
        StWrite: begin
          gap_d   = GapLast;
          state_d = StGap;
        end
        StGap: begin
          if (gap_q == 8'd0) state_d = StSelect;
          else               gap_d   = gap_q - 8'd1;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StDone);
    strobe_d = '0;
    if (state_d == StWrite) strobe_d[idx_q] = 1'b1;
    dx_mag = r[4] ? DXY_WIDTH'(2) : DXY_WIDTH'(1);
    x_d    = sprite_x;
    y_d    = sprite_y;
    dx_d   = sprite_dx;
    dy_d   = sprite_dy;
    if (latch_bus) begin
      x_d  = X_WIDTH'(fold_x(16'(r[X_WIDTH-1:0]), XMax));
      y_d  = Y_WIDTH'(r[15:10]);
      dx_d = r[3] ? -dx_mag : dx_mag;
      dy_d = DXY_WIDTH'(1);
    end
  end

  assign sprite_write_xy  = strobe_q;
  assign sprite_write_dxy = strobe_q;

endmodule

// File: tb/tb_target_spawn_scheduler.sv
// Directed and randomized checks of target_spawn_scheduler against a behavioural model.
module tb_target_spawn_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] enable_mask = 3'b000;
  logic       vblank = 1'b0;
  logic       busy, done;
  logic [2:0] spawned_mask, sprite_write_xy, sprite_write_dxy;
  logic [9:0] sprite_x;
  logic [8:0] sprite_y;
  logic [2:0] sprite_dx, sprite_dy;

  target_spawn_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .enable_mask      (enable_mask),
    .vblank           (vblank),
    .busy             (busy),
    .done             (done),
    .spawned_mask     (spawned_mask),
    .sprite_write_xy  (sprite_write_xy),
    .sprite_write_dxy (sprite_write_dxy),
    .sprite_x         (sprite_x),
    .sprite_y         (sprite_y),
    .sprite_dx        (sprite_dx),
    .sprite_dy        (sprite_dy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference LFSR: value now, and value just before the latest edge.
  logic [15:0] m_lfsr, m_prev;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr = 16'hACE1;
      m_prev = 16'hACE1;
    end else begin
      m_prev = m_lfsr;
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  int exp_x = 0, exp_y = 0, exp_dx = 0, exp_dy = 0;
  int strobe_cyc[$];
  int strobe_tgt[$];
  int done_cyc, n_done, busy_first, busy_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic vbl_val(input int vmode, input int c);
    if (vmode == 0) return 1'b1;
    if (vmode > 0)  return (c >= vmode);
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic int popcount3(input logic [2:0] m);
    return int'(m[0]) + int'(m[1]) + int'(m[2]);
  endfunction

  // vmode: 0 = vblank high, >0 = vblank rises in that cycle, <0 = random per cycle.
  task automatic run_seq(input logic [2:0] mask, input int vmode, input int abort_at,
                         input bit stray);
    int c;
    int raw, mag;
    logic [2:0] rem, exp_stb;
    logic vs;
    strobe_cyc.delete();
    strobe_tgt.delete();
    done_cyc = -1; n_done = 0; busy_first = -1; busy_last = -1;
    rem = mask;
    enable_mask = mask;
    start = 1'b1;
    abort = (abort_at == 0);
    vblank = vbl_val(vmode, 0);
    vs = vblank;
    step();
    start = 1'b0;
    abort = 1'b0;
    enable_mask = 3'($urandom);
    for (c = 1; c <= 400; c++) begin
      if (busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (done) begin
        n_done++;
        done_cyc = c;
      end
      chk("xy_dxy_same", 32'(sprite_write_dxy), 32'(sprite_write_xy));
      if (sprite_write_xy != 3'b000) begin
        exp_stb = rem & (~rem + 3'd1);
        chk("strobe_target", 32'(sprite_write_xy), 32'(exp_stb));
        chk("strobe_in_vblank", 32'(vs), 32'd1);
        strobe_cyc.push_back(c);
        for (int t = 0; t < 3; t++) if (sprite_write_xy[t]) strobe_tgt.push_back(t);
        rem = rem & ~exp_stb;
        raw = int'(m_prev & 16'h03FF);
        exp_x = (raw <= 632) ? raw : raw - 633;
        exp_y = int'(m_prev >> 10);
        mag = 1 + int'(m_prev[4]);
        exp_dx = m_prev[3] ? -mag : mag;
        exp_dy = 1;
        chk("x_range", 32'(sprite_x <= 10'd632), 32'd1);
        chk("y_range", 32'(sprite_y <= 9'd63), 32'd1);
        chk("dx_set", 32'($signed(sprite_dx) inside {-2, -1, 1, 2}), 32'd1);
      end
      chk("sprite_x", 32'(sprite_x), 32'(exp_x));
      chk("sprite_y", 32'(sprite_y), 32'(exp_y));
      chk("sprite_dx", 32'($signed(sprite_dx)), 32'(exp_dx));
      chk("sprite_dy", 32'($signed(sprite_dy)), 32'(exp_dy));
      chk("lfsr_nonzero", 32'(dut.u_lfsr.value != 16'h0000), 32'd1);
      if (!busy && c >= 2) break;
      vblank = vbl_val(vmode, c);
      vs = vblank;
      abort = (c == abort_at);
      if (stray && busy && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        enable_mask = 3'($urandom);
      end
      step();
      start = 1'b0;
      abort = 1'b0;
    end
    chk("seq_timeout", 32'(c <= 400), 32'd1);
    vblank = 1'b0;
  endtask

  initial begin
    logic [2:0] m;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_strobe", 32'(sprite_write_xy), 32'd0);
    chk("rst_x", 32'(sprite_x), 32'd0);
    chk("rst_lfsr", 32'(dut.u_lfsr.value), 32'hACE1);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Two targets, vblank held high.
    run_seq(3'b101, 0, -1, 1'b0);
    chk("t1_nstrobe", 32'(strobe_cyc.size()), 32'd2);
    if (strobe_cyc.size() == 2) begin
      chk("t1_strobe0_cyc", 32'(strobe_cyc[0]), 32'd3);
      chk("t1_strobe0_tgt", 32'(strobe_tgt[0]), 32'd0);
      chk("t1_strobe1_cyc", 32'(strobe_cyc[1]), 32'd10);
      chk("t1_strobe1_tgt", 32'(strobe_tgt[1]), 32'd2);
    end
    chk("t1_done_cyc", 32'(done_cyc), 32'd16);
    chk("t1_ndone", 32'(n_done), 32'd1);
    chk("t1_busy_first", 32'(busy_first), 32'd1);
    chk("t1_busy_last", 32'(busy_last), 32'd16);
    chk("t1_spawned", 32'(spawned_mask), 32'b101);

    // vblank held low until cycle 20.
    run_seq(3'b111, 20, -1, 1'b0);
    chk("t2_nstrobe", 32'(strobe_cyc.size()), 32'd3);
    if (strobe_cyc.size() == 3) begin
      chk("t2_first_cyc", 32'(strobe_cyc[0]), 32'd21);
      chk("t2_second_cyc", 32'(strobe_cyc[1]), 32'd28);
      chk("t2_third_cyc", 32'(strobe_cyc[2]), 32'd35);
    end
    chk("t2_done_cyc", 32'(done_cyc), 32'd41);
    chk("t2_spawned", 32'(spawned_mask), 32'b111);

    // Empty mask.
    run_seq(3'b000, 0, -1, 1'b0);
    chk("t3_nstrobe", 32'(strobe_cyc.size()), 32'd0);
    chk("t3_done_cyc", 32'(done_cyc), 32'd2);
    chk("t3_spawned", 32'(spawned_mask), 32'd0);

    // Abort on the first gap cycle, then a fresh sequence.
    run_seq(3'b111, 0, 4, 1'b0);
    chk("t4_nstrobe", 32'(strobe_cyc.size()), 32'd1);
    chk("t4_ndone", 32'(n_done), 32'd0);
    chk("t4_busy_last", 32'(busy_last), 32'd4);
    chk("t4_spawned", 32'(spawned_mask), 32'b001);
    run_seq(3'b111, 0, -1, 1'b0);
    chk("t4b_nstrobe", 32'(strobe_cyc.size()), 32'd3);
    chk("t4b_done_cyc", 32'(done_cyc), 32'd23);
    chk("t4b_spawned", 32'(spawned_mask), 32'b111);

    // start and abort together in IDLE: nothing starts.
    enable_mask = 3'b111;
    start = 1'b1;
    abort = 1'b1;
    vblank = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("t5_busy0", 32'(busy), 32'd0);
    step();
    chk("t5_busy1", 32'(busy), 32'd0);
    chk("t5_strobe", 32'(sprite_write_xy), 32'd0);
    vblank = 1'b0;

    // Randomized sequences with stray starts during busy.
    for (int s = 0; s < 1000; s++) begin
      m = 3'($urandom);
      run_seq(m, -1, -1, 1'b1);
      chk("rnd_spawned", 32'(spawned_mask), 32'(m));
      chk("rnd_ndone", 32'(n_done), 32'd1);
      chk("rnd_nstrobe", 32'(strobe_cyc.size()), 32'(popcount3(m)));
    end
    chk("lfsr_track", 32'(dut.u_lfsr.value), 32'(m_lfsr));

    // Reset while waiting for vblank.
    enable_mask = 3'b010;
    start = 1'b1;
    vblank = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    chk("t6_busy_pre", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    exp_x = 0; exp_y = 0; exp_dx = 0; exp_dy = 0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_spawned", 32'(spawned_mask), 32'd0);
    chk("t6_strobe", 32'({sprite_write_xy, sprite_write_dxy}), 32'd0);
    chk("t6_bus", 32'({sprite_x, sprite_y, sprite_dx, sprite_dy}), 32'd0);
    chk("t6_lfsr", 32'(dut.u_lfsr.value), 32'hACE1);
    @(negedge clk);
    rst = 1'b0;
    step();
    run_seq(3'b010, 0, -1, 1'b0);
    chk("t6_nstrobe", 32'(strobe_cyc.size()), 32'd1);
    if (strobe_cyc.size() == 1) begin
      chk("t6_strobe_cyc", 32'(strobe_cyc[0]), 32'd3);
      chk("t6_strobe_tgt", 32'(strobe_tgt[0]), 32'd1);
    end
    chk("t6_done_cyc", 32'(done_cyc), 32'd9);
    chk("t6_spawned_end", 32'(spawned_mask), 32'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
